// File: rtl/banner_sprite.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | banner_sprite: animated, blinking, colour-keyed sprite over a ROM image   |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module banner_sprite #(
  parameter int unsigned WIDTH       = 110,
  parameter int unsigned HEIGHT      = 75,
  parameter int unsigned X0          = 265,
  parameter int unsigned Y0          = 203,
  parameter int unsigned SCALE_LOG2  = 0,
  parameter int unsigned NUM_FRAMES  = 1,
  parameter int unsigned FRAME_TICKS = 8,
  parameter int unsigned BLINK_TICKS = 0,
  parameter logic [11:0] KEY         = 12'h0F0,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_tick,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              sprite_on,
  output logic [11:0]       pixel
);

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + (WIDTH << SCALE_LOG2));
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + (HEIGHT << SCALE_LOG2));
  localparam int unsigned FRAME_SIZE = WIDTH * HEIGHT;
  localparam int unsigned TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [10:0]        h_ext, v_ext, dx, dy;
  logic               in_box;
  logic               in_box_d_q;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]         frame_idx_q, frame_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               visible_q, visible_d;
  logic               sprite_on_q, sprite_on_d;
  logic [11:0]        pixel_q, pixel_d;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign in_box = (h_ext >= X_LO) && (h_ext < X_HI) && (v_ext >= Y_LO) && (v_ext < Y_HI);
  assign dx     = (h_ext - X_LO) >> SCALE_LOG2;
  assign dy     = (v_ext - Y_LO) >> SCALE_LOG2;

  always_comb begin
    rom_addr = '0;
    if (in_box) begin
      rom_addr = ADDR_W'(32'(frame_idx_q) * 32'(FRAME_SIZE)
                       + 32'(dy) * 32'(WIDTH) + 32'(dx));
    end
  end

  // Animation and blink counters only move on enabled frame ticks.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    frame_idx_d = frame_idx_q;
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    if (!enable) begin
      tick_cnt_d  = '0;
      frame_idx_d = '0;
      blink_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (frame_tick) begin
      if (tick_cnt_q == TICK_W'(FRAME_TICKS - 1)) begin
        tick_cnt_d  = '0;
        frame_idx_d = (frame_idx_q == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_idx_q + 3'd1;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
      if (BLINK_TICKS != 0) begin
        if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
          blink_cnt_d = '0;
          visible_d   = ~visible_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end
    end
  end

  always_comb begin
    sprite_on_d = in_box_d_q & enable & visible_q & (rom_data != KEY);
    pixel_d     = sprite_on_d ? rom_data : 12'h000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_box_d_q  <= 1'b0;
      tick_cnt_q  <= '0;
      frame_idx_q <= '0;
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
      sprite_on_q <= 1'b0;
      pixel_q     <= 12'h000;
    end else begin
      in_box_d_q  <= in_box;
      tick_cnt_q  <= tick_cnt_d;
      frame_idx_q <= frame_idx_d;
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
      sprite_on_q <= sprite_on_d;
      pixel_q     <= pixel_d;
    end
  end

  assign sprite_on = sprite_on_q;
  assign pixel     = pixel_q;

endmodule
`default_nettype wire

// File: tb/tb_banner_sprite.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_banner_sprite: three sprite configurations against a behavioural model |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_banner_sprite;

  localparam logic [11:0] KEY = 12'h0F0;
  // Per-instance configuration: 0 = defaults, 1 = 2x scale, 2 = animated + blinking.
  localparam int S_L2[3] = '{0, 1, 0};
  localparam int NF[3]   = '{1, 1, 3};
  localparam int FT[3]   = '{8, 8, 2};
  localparam int BT[3]   = '{0, 0, 2};
  localparam int ROWS[7]  = '{202, 203, 240, 277, 278, 352, 353};
  localparam int COLS[16] = '{0, 263, 264, 265, 266, 267, 372, 373, 374, 375, 376, 483, 484, 485, 486, 1023};
  localparam int ANIM_ADDR[7] = '{0, 0, 8250, 8250, 16500, 16500, 0};
  localparam int ANIM_VIS[7]  = '{1, 1, 0, 0, 1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b1;
  logic [16:0] addr_w[3];
  logic [11:0] rdat[3];
  logic        on_w[3];
  logic [11:0] pix_w[3];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  banner_sprite dut_a (
    .clk(clk), .rst(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_tick(frame_tick),
    .enable(enable), .rom_addr(addr_w[0]), .rom_data(rdat[0]), .sprite_on(on_w[0]), .pixel(pix_w[0])
  );
  banner_sprite #(.SCALE_LOG2(1)) dut_b (
    .clk(clk), .rst(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_tick(frame_tick),
    .enable(enable), .rom_addr(addr_w[1]), .rom_data(rdat[1]), .sprite_on(on_w[1]), .pixel(pix_w[1])
  );
  banner_sprite #(.NUM_FRAMES(3), .FRAME_TICKS(2), .BLINK_TICKS(2)) dut_c (
    .clk(clk), .rst(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_tick(frame_tick),
    .enable(enable), .rom_addr(addr_w[2]), .rom_data(rdat[2]), .sprite_on(on_w[2]), .pixel(pix_w[2])
  );

  // Image content: every seventh texel (offset 3) is the transparent key.
  function automatic logic [11:0] rom_fn(int a);
    if (a % 7 == 3) return KEY;
    return 12'(a * 37 + 32'hF00);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rdat[i] <= rom_fn(int'(addr_w[i]));
  end

  function automatic bit m_in_box(int i, int h, int v);
    int sz = 1 << S_L2[i];
    return (h >= 265) && (h < 265 + 110 * sz) && (v >= 203) && (v < 203 + 75 * sz);
  endfunction

  // n = enabled frame ticks since reset or the last enable drop.
  function automatic int exp_addr(int i, int h, int v, int n);
    int fr;
    if (!m_in_box(i, h, v)) return 0;
    fr = (n / FT[i]) % NF[i];
    return (fr * 110 * 75 + ((v - 203) >> S_L2[i]) * 110 + ((h - 265) >> S_L2[i])) % (1 << 17);
  endfunction

  function automatic bit m_vis(int i, int n);
    if (BT[i] == 0) return 1'b1;
    return ((n / BT[i]) % 2) == 0;
  endfunction

  int          n[3]       = '{0, 0, 0};
  bit          s1_in[3]   = '{0, 0, 0};
  logic [11:0] s1_data[3] = '{12'h0, 12'h0, 12'h0};
  bit          e_on[3]    = '{0, 0, 0};
  logic [11:0] e_pix[3]   = '{12'h0, 12'h0, 12'h0};
  bit          armed = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        n[i] <= 0; s1_in[i] <= 1'b0; e_on[i] <= 1'b0; e_pix[i] <= 12'h000;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic bit on_n = s1_in[i] && enable && m_vis(i, n[i]) && (s1_data[i] != KEY);
        e_on[i]    <= on_n;
        e_pix[i]   <= on_n ? s1_data[i] : 12'h000;
        s1_in[i]   <= m_in_box(i, int'(h_cnt), int'(v_cnt));
        s1_data[i] <= rom_fn(exp_addr(i, int'(h_cnt), int'(v_cnt), n[i]));
        n[i]       <= !enable ? 0 : (frame_tick ? n[i] + 1 : n[i]);
      end
    end
  end

  always @(posedge clk) armed <= 1'b1;

  task automatic chk(string nm, int idx, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk("rom_addr", i, int'(addr_w[i]), exp_addr(i, int'(h_cnt), int'(v_cnt), n[i]));
        chk("sprite_on", i, int'(on_w[i]), int'(e_on[i]));
        chk("pixel", i, int'(pix_w[i]), int'(e_pix[i]));
      end
    end
  end

  task automatic step(int h, int v, bit tk);
    @(posedge clk);
    #1;
    h_cnt      = 10'(h);
    v_cnt      = 10'(v);
    frame_tick = tk;
  endtask

  // Two idle cycles so the output reflects the pixel presented before them.
  task automatic drain();
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    step(265, 203, 1'b0); #1;
    chk("lit_addr_origin", 0, int'(addr_w[0]), 0);
    drain();
    chk("lit_on_origin", 0, int'(on_w[0]), 1);
    chk("lit_pix_origin", 0, int'(pix_w[0]), 'hF00);

    step(374, 277, 1'b0); #1;
    chk("lit_addr_corner", 0, int'(addr_w[0]), 8249);
    step(375, 277, 1'b0); #1;
    chk("lit_addr_right_out", 0, int'(addr_w[0]), 0);
    drain();
    chk("lit_on_right_out", 0, int'(on_w[0]), 0);

    step(268, 203, 1'b0); #1;
    chk("lit_addr_key", 0, int'(addr_w[0]), 3);
    drain();
    chk("lit_on_key", 0, int'(on_w[0]), 0);
    chk("lit_pix_key", 0, int'(pix_w[0]), 0);

    step(267, 205, 1'b0); #1;
    chk("lit_addr_scaled", 1, int'(addr_w[1]), 111);
    step(484, 205, 1'b0); #1;
    chk("lit_addr_scaled_edge", 1, int'(addr_w[1]), 219);
    step(485, 205, 1'b0); #1;
    chk("lit_addr_scaled_out", 1, int'(addr_w[1]), 0);

    for (int k = 0; k < 7; k++) begin
      if (k > 0) step(0, 0, 1'b1);
      step(265, 203, 1'b0); #1;
      chk("lit_anim_addr", k, int'(addr_w[2]), ANIM_ADDR[k]);
      drain();
      chk("lit_anim_visible", k, int'(on_w[2]), ANIM_VIS[k]);
    end

    repeat (3) step(0, 0, 1'b1);
    step(265, 203, 1'b0); #1;
    chk("lit_anim_before_drop", 2, int'(addr_w[2]), 8250);
    enable = 1'b0;
    step(0, 0, 1'b1);
    step(0, 0, 1'b0);
    enable = 1'b1;
    step(265, 203, 1'b0); #1;
    chk("lit_reenable_addr", 2, int'(addr_w[2]), 0);
    drain();
    chk("lit_reenable_visible", 2, int'(on_w[2]), 1);

    repeat (3) step(270, 210, 1'b0);
    #1;
    chk("lit_on_before_rst", 0, int'(on_w[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_on", 0, int'(on_w[0]), 0);
    chk("lit_rst_pix", 0, int'(pix_w[0]), 0);
    chk("lit_rst_on_c", 2, int'(on_w[2]), 0);
    step(270, 210, 1'b0);
    step(270, 210, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(265, 203, 1'b0);
    drain();
    chk("lit_on_after_rst", 0, int'(on_w[0]), 1);
    chk("lit_pix_after_rst", 0, int'(pix_w[0]), 'hF00);

    for (int r = 0; r < 7; r++) begin
      enable = (r != 2);
      for (int c = 0; c < 16; c++) step(COLS[c], ROWS[r], (c == 0) && (r % 2 == 1));
    end
    enable = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
